// File: rtl/uart_axi_bridge_if.sv
// AXI4 channel bundle used by the UART debug bridge: single-beat subset with IDs.
// Response encoding on b_resp/r_resp: 0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR.
`timescale 1ns/1ps
interface axi4 #(
    parameter int unsigned idlen = 4
);
    logic [idlen-1:0] aw_id;
    logic [31:0]      aw_addr;
    logic [7:0]       aw_len;
    logic [2:0]       aw_size;
    logic [1:0]       aw_burst;
    logic             aw_valid;
    logic             aw_ready;

    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             w_last;
    logic             w_valid;
    logic             w_ready;

    logic [idlen-1:0] b_id;
    logic [1:0]       b_resp;
    logic             b_valid;
    logic             b_ready;

    logic [idlen-1:0] ar_id;
    logic [31:0]      ar_addr;
    logic [7:0]       ar_len;
    logic [2:0]       ar_size;
    logic [1:0]       ar_burst;
    logic             ar_valid;
    logic             ar_ready;

    logic [idlen-1:0] r_id;
    logic [31:0]      r_data;
    logic [1:0]       r_resp;
    logic             r_last;
    logic             r_valid;
    logic             r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/uart_axi_bridge.sv
// UART-to-AXI4 debug master: decodes 'W'/'R' frames from the RX byte stream, performs a
// single-beat 32-bit AXI access and streams the status (plus read data) back on TX.
// ID_W must equal the idlen of the connected axi4 interface.
`timescale 1ns/1ps
module uart_axi_bridge #(
    parameter int unsigned     ID_W           = 4,
    parameter logic [ID_W-1:0] AXI_ID         = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    axi4.master        bus,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       rx_drop
);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, AXI_WR, AXI_B, AXI_AR, AXI_R, RESP
    } state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] timeout_cnt;
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_write;
    logic        reply_short;
    logic [7:0]  status;
    logic [2:0]  tx_idx;
    logic        aw_done;
    logic        w_done;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, tx_hs, tx_last, timeout_hit;
    logic unused_bits;

    assign aw_hs   = bus.aw_valid && bus.aw_ready;
    assign w_hs    = bus.w_valid && bus.w_ready;
    assign b_hs    = bus.b_valid && bus.b_ready;
    assign ar_hs   = bus.ar_valid && bus.ar_ready;
    assign r_hs    = bus.r_valid && bus.r_ready;
    assign tx_hs   = tx_valid && tx_ready;
    assign tx_last = reply_short || (tx_idx == 3'd4);

    // A frame is abandoned when no byte has arrived for TIMEOUT_CYCLES consecutive cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !rx_valid &&
                         (timeout_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Responses carry no information we act on beyond resp/data, so IDs and r_last are ignored.
    assign unused_bits = ^{bus.b_id, bus.r_id, bus.r_last};

    // Fixed single-beat, full-word attributes.
    assign bus.aw_id    = AXI_ID;
    assign bus.aw_addr  = addr;
    assign bus.aw_len   = 8'd0;
    assign bus.aw_size  = 3'd2;
    assign bus.aw_burst = 2'b01;
    assign bus.w_data   = data;
    assign bus.w_strb   = 4'hF;
    assign bus.w_last   = 1'b1;
    assign bus.ar_id    = AXI_ID;
    assign bus.ar_addr  = addr;
    assign bus.ar_len   = 8'd0;
    assign bus.ar_size  = 3'd2;
    assign bus.ar_burst = 2'b01;

    // Handshake outputs are pure decodes of registered state, so they are glitch-free.
    assign bus.aw_valid = (state == AXI_WR) && !aw_done;
    assign bus.w_valid  = (state == AXI_WR) && !w_done;
    assign bus.b_ready  = (state == AXI_B);
    assign bus.ar_valid = (state == AXI_AR);
    assign bus.r_ready  = (state == AXI_R);
    assign tx_valid     = (state == RESP);
    assign busy         = (state != IDLE);
    assign rx_drop      = rx_valid && (state inside {AXI_WR, AXI_B, AXI_AR, AXI_R, RESP});

    // Reply byte selection: status first, then read data little-endian.
    always_comb begin
        tx_data = 8'h00;
        case (tx_idx)
            3'd0:    tx_data = status;
            3'd1:    tx_data = data[7:0];
            3'd2:    tx_data = data[15:8];
            3'd3:    tx_data = data[23:16];
            3'd4:    tx_data = data[31:24];
            default: tx_data = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the command/transaction/reply sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_next = (rx_data == CMD_W || rx_data == CMD_R) ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (rx_valid && byte_cnt == 2'd3) begin
                    state_next = is_write ? DATA : AXI_AR;
                end
            end
            DATA: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (rx_valid && byte_cnt == 2'd3) begin
                    state_next = AXI_WR;
                end
            end
            AXI_WR: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = AXI_B;
                end
            end
            AXI_B:   if (b_hs)  state_next = RESP;
            AXI_AR:  if (ar_hs) state_next = AXI_R;
            AXI_R:   if (r_hs)  state_next = RESP;
            RESP:    if (tx_hs && tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: byte capture, timeout counting, handshake bookkeeping and reply indexing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= 2'd0;
            timeout_cnt <= 32'd0;
            addr        <= 32'd0;
            data        <= 32'd0;
            is_write    <= 1'b0;
            reply_short <= 1'b0;
            status      <= 8'h00;
            tx_idx      <= 3'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt    <= 2'd0;
                    timeout_cnt <= 32'd0;
                    tx_idx      <= 3'd0;
                    aw_done     <= 1'b0;
                    w_done      <= 1'b0;
                    if (rx_valid) begin
                        is_write    <= (rx_data == CMD_W);
                        reply_short <= (rx_data != CMD_R);
                        status      <= 8'hFF;
                    end
                end
                ADDR, DATA: begin
                    if (rx_valid) begin
                        if (state == ADDR) begin
                            addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        end else begin
                            data[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        end
                        byte_cnt    <= byte_cnt + 2'd1;
                        timeout_cnt <= 32'd0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                AXI_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                AXI_B: begin
                    if (b_hs) status <= {6'b0, bus.b_resp};
                end
                AXI_R: begin
                    if (r_hs) begin
                        status <= {6'b0, bus.r_resp};
                        data   <= bus.r_data;
                    end
                end
                RESP: begin
                    if (tx_hs) tx_idx <= tx_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Bench for uart_axi_bridge: UART frames in, behavioural AXI slave, reply bytes scoreboarded.
`timescale 1ns/1ps
module tb_uart_axi_bridge;

    localparam int unsigned TO_CYC = 16;
    localparam logic [3:0]  TB_ID  = 4'h3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       rx_drop;

    axi4 #(.idlen(4)) bus ();

    uart_axi_bridge #(
        .ID_W(4),
        .AXI_ID(TB_ID),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_cfg = 2'd0, r_resp_cfg = 2'd0;
    logic [31:0] r_data_cfg = 32'd0;
    logic        tx_hold = 1'b0;

    // Handshake counters and captured request fields
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int b_given = 0, r_given = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    int drop_cnt = 0;
    logic [31:0] cap_aw_addr, cap_w_data, cap_ar_addr;
    logic [3:0]  cap_w_strb, cap_aw_id, cap_ar_id;
    logic        cap_w_last;
    logic [12:0] cap_aw_attr, cap_ar_attr;

    logic [7:0] exp_tx[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // TX acceptance is changed just after each rising edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = !tx_hold;
        end
    end

    // AXI slave: drives ready/response at the falling edge, then notes handshakes due next edge.
    initial begin
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
        bus.b_valid  = 1'b0; bus.b_resp  = 2'd0; bus.b_id     = '0;
        bus.r_valid  = 1'b0; bus.r_resp  = 2'd0; bus.r_id     = '0;
        bus.r_data   = 32'd0; bus.r_last = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.aw_ready) begin bus.aw_ready = 1'b0; aw_wait = 0; end
            else if (bus.aw_valid) begin
                if (aw_wait >= aw_delay) bus.aw_ready = 1'b1; else aw_wait++;
            end else aw_wait = 0;

            if (bus.w_ready) begin bus.w_ready = 1'b0; w_wait = 0; end
            else if (bus.w_valid) begin
                if (w_wait >= w_delay) bus.w_ready = 1'b1; else w_wait++;
            end else w_wait = 0;

            if (bus.ar_ready) begin bus.ar_ready = 1'b0; ar_wait = 0; end
            else if (bus.ar_valid) begin
                if (ar_wait >= ar_delay) bus.ar_ready = 1'b1; else ar_wait++;
            end else ar_wait = 0;

            if (bus.b_valid) begin
                if (b_cnt == b_given) bus.b_valid = 1'b0;
            end else if (aw_cnt > b_given && w_cnt > b_given) begin
                bus.b_valid = 1'b1; bus.b_resp = b_resp_cfg; b_given++;
            end

            if (bus.r_valid) begin
                if (r_cnt == r_given) bus.r_valid = 1'b0;
            end else if (ar_cnt > r_given) begin
                bus.r_valid = 1'b1; bus.r_resp = r_resp_cfg; bus.r_data = r_data_cfg; r_given++;
            end

            if (bus.aw_valid && bus.aw_ready) begin
                aw_cnt++;
                cap_aw_addr = bus.aw_addr;
                cap_aw_id   = bus.aw_id;
                cap_aw_attr = {bus.aw_len, bus.aw_size, bus.aw_burst};
            end
            if (bus.w_valid && bus.w_ready) begin
                w_cnt++;
                cap_w_data = bus.w_data;
                cap_w_strb = bus.w_strb;
                cap_w_last = bus.w_last;
            end
            if (bus.ar_valid && bus.ar_ready) begin
                ar_cnt++;
                cap_ar_addr = bus.ar_addr;
                cap_ar_id   = bus.ar_id;
                cap_ar_attr = {bus.ar_len, bus.ar_size, bus.ar_burst};
            end
            if (bus.b_valid && bus.b_ready) b_cnt++;
            if (bus.r_valid && bus.r_ready) r_cnt++;
        end
    end

    // Reply scoreboard and drop-pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_drop) drop_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) checkOutput("tx_unexpected_byte", 32'(exp_tx.size()), 32'd1);
                else checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end else if (tx_valid && exp_tx.size() != 0) begin
                checkOutput("tx_stable", {24'd0, tx_data}, {24'd0, exp_tx[0]});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        sendByte(cmd);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            for (int i = 0; i < 4; i++) sendByte(addr[8*i +: 8]);
        end
        if (cmd == 8'h57) begin
            for (int i = 0; i < 4; i++) sendByte(data[8*i +: 8]);
        end
    endtask

    task automatic expectRead(input logic [1:0] resp, input logic [31:0] d);
        exp_tx.push_back({6'd0, resp});
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(n < 500), 32'd1);
    endtask

    task automatic checkWrite(input string tag, input int a0, input int w0,
                              input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, "_aw_count"}, 32'(aw_cnt - a0), 32'd1);
        checkOutput({tag, "_w_count"}, 32'(w_cnt - w0), 32'd1);
        checkOutput({tag, "_aw_addr"}, cap_aw_addr, addr);
        checkOutput({tag, "_w_data"}, cap_w_data, data);
    endtask

    initial begin
        int a0, w0, r0, d0, n;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {24'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready,
                     bus.r_ready, tx_valid, busy, rx_drop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);

        $display("[TB] write 0x10000000 <- 0xDEADBEEF");
        a0 = aw_cnt; w0 = w_cnt;
        exp_tx.push_back(8'h00);
        applyStimulus(8'h57, 32'h1000_0000, 32'hDEAD_BEEF);
        waitIdle("write1_done");
        checkWrite("write1", a0, w0, 32'h1000_0000, 32'hDEAD_BEEF);
        checkOutput("write1_strb", {28'd0, cap_w_strb}, 32'hF);
        checkOutput("write1_last", {31'd0, cap_w_last}, 32'd1);
        checkOutput("write1_attr", {19'd0, cap_aw_attr}, {19'd0, 8'd0, 3'd2, 2'd1});
        checkOutput("write1_id", {28'd0, cap_aw_id}, {28'd0, TB_ID});

        $display("[TB] read 0x10000004 OKAY");
        r0 = ar_cnt;
        r_data_cfg = 32'h0001_2345; r_resp_cfg = 2'd0;
        expectRead(2'd0, 32'h0001_2345);
        applyStimulus(8'h52, 32'h1000_0004, 32'd0);
        waitIdle("read1_done");
        checkOutput("read1_ar_count", 32'(ar_cnt - r0), 32'd1);
        checkOutput("read1_ar_addr", cap_ar_addr, 32'h1000_0004);
        checkOutput("read1_attr", {19'd0, cap_ar_attr}, {19'd0, 8'd0, 3'd2, 2'd1});
        checkOutput("read1_id", {28'd0, cap_ar_id}, {28'd0, TB_ID});

        $display("[TB] read unmapped SLVERR");
        r_data_cfg = 32'd0; r_resp_cfg = 2'd2;
        expectRead(2'd2, 32'd0);
        applyStimulus(8'h52, 32'hF000_0000, 32'd0);
        waitIdle("read2_done");

        $display("[TB] write with aw_ready first");
        aw_delay = 0; w_delay = 3; b_resp_cfg = 2'd0;
        a0 = aw_cnt; w0 = w_cnt;
        exp_tx.push_back(8'h00);
        applyStimulus(8'h57, 32'h2000_0008, 32'h1234_5678);
        waitIdle("write2_done");
        checkWrite("write2", a0, w0, 32'h2000_0008, 32'h1234_5678);

        $display("[TB] write with w_ready first, SLVERR");
        aw_delay = 3; w_delay = 0; b_resp_cfg = 2'd2;
        a0 = aw_cnt; w0 = w_cnt;
        exp_tx.push_back(8'h02);
        applyStimulus(8'h57, 32'h2000_000C, 32'h0BAD_CAFE);
        waitIdle("write3_done");
        checkWrite("write3", a0, w0, 32'h2000_000C, 32'h0BAD_CAFE);
        aw_delay = 0; w_delay = 0; b_resp_cfg = 2'd0;

        $display("[TB] unknown command 0x41");
        exp_tx.push_back(8'hFF);
        sendByte(8'h41);
        waitIdle("badcmd_done");

        $display("[TB] partial frame timeout");
        sendByte(8'h57);
        sendByte(8'h00);
        sendByte(8'h11);
        repeat (TO_CYC - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_not_yet", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
        r_data_cfg = 32'hCAFE_F00D; r_resp_cfg = 2'd0;
        expectRead(2'd0, 32'hCAFE_F00D);
        applyStimulus(8'h52, 32'h1000_0010, 32'd0);
        waitIdle("read_after_timeout_done");
        checkOutput("read_after_timeout_addr", cap_ar_addr, 32'h1000_0010);

        $display("[TB] stalled reply with dropped rx bytes");
        tx_hold = 1'b1;
        d0 = drop_cnt;
        r_data_cfg = 32'hA5B6_C7D8;
        expectRead(2'd0, 32'hA5B6_C7D8);
        applyStimulus(8'h52, 32'h3000_0000, 32'd0);
        n = 0;
        while (!tx_valid && n < 200) begin @(negedge clk); n++; end
        checkOutput("stall_reply_started", 32'(n < 200), 32'd1);
        sendByte(8'h57);
        sendByte(8'h52);
        sendByte(8'h33);
        repeat (4) @(posedge clk);
        checkOutput("stall_no_byte_sent", 32'(exp_tx.size()), 32'd5);
        tx_hold = 1'b0;
        waitIdle("stall_done");
        checkOutput("stall_drop_count", 32'(drop_cnt - d0), 32'd3);

        $display("[TB] reset during AXI_AR");
        ar_delay = 100;
        applyStimulus(8'h52, 32'h4000_0000, 32'd0);
        n = 0;
        while (!bus.ar_valid && n < 200) begin @(negedge clk); n++; end
        checkOutput("ar_pending_seen", 32'(n < 200), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_ar",
                    {25'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready,
                     bus.r_ready, tx_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ar_delay = 0;
        r_data_cfg = 32'h0BAD_F00D;
        expectRead(2'd0, 32'h0BAD_F00D);
        applyStimulus(8'h52, 32'h1000_0020, 32'd0);
        waitIdle("read_after_reset_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
